// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR receiver: FSM state encoding and the
// pulse-width windows, all expressed in 10 us ticks.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LO,
        LEAD_HI,
        BIT_LO,
        BIT_HI,
        RPT_LO
    } state_t;

    localparam logic [11:0] LEAD_LO_MIN = 12'd800;   // 9 ms leader burst
    localparam logic [11:0] LEAD_LO_MAX = 12'd1000;
    localparam logic [11:0] LEAD_HI_MIN = 12'd400;   // 4.5 ms frame space
    localparam logic [11:0] LEAD_HI_MAX = 12'd500;
    localparam logic [11:0] RPT_HI_MIN  = 12'd180;   // 2.25 ms repeat space
    localparam logic [11:0] RPT_HI_MAX  = 12'd270;
    localparam logic [11:0] BURST_MIN   = 12'd40;    // 562 us burst / zero space
    localparam logic [11:0] BURST_MAX   = 12'd70;
    localparam logic [11:0] ONE_MIN     = 12'd140;   // 1.69 ms one space
    localparam logic [11:0] ONE_MAX     = 12'd200;
    localparam logic [11:0] TIMEOUT     = 12'd1100;  // no edge for 11 ms aborts
    localparam logic [11:0] WIDTH_SAT   = 12'hFFF;

    function automatic logic in_window(input logic [11:0] w,
                                       input logic [11:0] lo,
                                       input logic [11:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Conditions the raw IR input and measures the time between its edges.
// Produces a 10 us tick, one-cycle rise/fall strobes of the synchronised
// signal, and the saturating tick count since the previous edge.
module ir_pulse_timer
    import ir_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        signal,
    output logic        tick,
    output logic        rise,
    output logic        fall,
    output logic [11:0] width
);

    localparam int DIV   = (CLK_HZ / 100_000 > 0) ? CLK_HZ / 100_000 : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level_q;
    logic [DIV_W-1:0] pre;

    // Two-flop synchroniser plus a delayed copy for edge detection; idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync_a  <= signal;
            sync_b  <= sync_a;
            level_q <= sync_b;
        end
    end

    assign rise = sync_b & ~level_q;
    assign fall = ~sync_b & level_q;
    assign tick = (pre == DIV_LAST);

    // Free-running prescaler producing one tick every DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (pre == DIV_LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Width counter restarts on each edge, so at an edge it holds the
    // duration of the pulse that edge terminates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width <= '0;
        end else if (rise || fall) begin
            width <= '0;
        end else if (tick && (width != WIDTH_SAT)) begin
            width <= width + 12'd1;
        end
    end

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC IR frame decoder: walks leader, 32 data bits and stop burst, checks
// the command/inverse pair, recognises repeat codes, and holds the decoded
// word only while the key is held (cleared after a release interval).
module ir_nec_receiver
    import ir_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int CHECK_INV     = 1,
    parameter int RELEASE_TICKS = 12000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Signal,
    output logic [31:0] Data,
    output logic        Valid,
    output logic        Repeat,
    output logic        Error
);

    localparam logic [31:0] RELEASE_LOAD = 32'(RELEASE_TICKS);

    logic        tick;
    logic        rise;
    logic        fall;
    logic [11:0] width;

    state_t      state;
    logic [31:0] shift;
    logic [5:0]  bit_cnt;
    logic [31:0] release_cnt;

    ir_pulse_timer #(
        .CLK_HZ(CLK_HZ)
    ) u_timer (
        .clk   (CLK),
        .rst_n (RST_N),
        .signal(Signal),
        .tick  (tick),
        .rise  (rise),
        .fall  (fall),
        .width (width)
    );

    // Decoder FSM with registered pulse outputs and the key-release timer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            release_cnt <= '0;
            Data        <= '0;
            Valid       <= 1'b0;
            Repeat      <= 1'b0;
            Error       <= 1'b0;
        end else begin
            Valid  <= 1'b0;
            Repeat <= 1'b0;
            Error  <= 1'b0;

            // Release timer; a frame load below overrides the clear.
            if (Valid || Repeat) begin
                release_cnt <= RELEASE_LOAD;
            end else if (tick && (release_cnt != '0)) begin
                release_cnt <= release_cnt - 32'd1;
                if (release_cnt == 32'd1) begin
                    Data <= '0;
                end
            end

            if ((state != IDLE) && !rise && !fall && (width >= TIMEOUT)) begin
                Error <= 1'b1;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall) begin
                            state <= LEAD_LO;
                        end
                    end
                    LEAD_LO: begin
                        if (rise) begin
                            if (in_window(width, LEAD_LO_MIN, LEAD_LO_MAX)) begin
                                state <= LEAD_HI;
                            end else begin
                                Error <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                    LEAD_HI: begin
                        if (fall) begin
                            if (in_window(width, LEAD_HI_MIN, LEAD_HI_MAX)) begin
                                bit_cnt <= '0;
                                state   <= BIT_LO;
                            end else if (in_window(width, RPT_HI_MIN, RPT_HI_MAX)) begin
                                state <= RPT_LO;
                            end else begin
                                Error <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                    BIT_LO: begin
                        if (rise) begin
                            if (!in_window(width, BURST_MIN, BURST_MAX)) begin
                                Error <= 1'b1;
                                state <= IDLE;
                            end else if (bit_cnt == 6'd32) begin
                                if ((CHECK_INV == 0) || (shift[31:24] == ~shift[23:16])) begin
                                    Data  <= shift;
                                    Valid <= 1'b1;
                                end else begin
                                    Error <= 1'b1;
                                end
                                state <= IDLE;
                            end else begin
                                state <= BIT_HI;
                            end
                        end
                    end
                    BIT_HI: begin
                        if (fall) begin
                            if (in_window(width, BURST_MIN, BURST_MAX)) begin
                                shift   <= {1'b0, shift[31:1]};
                                bit_cnt <= bit_cnt + 6'd1;
                                state   <= BIT_LO;
                            end else if (in_window(width, ONE_MIN, ONE_MAX)) begin
                                shift   <= {1'b1, shift[31:1]};
                                bit_cnt <= bit_cnt + 6'd1;
                                state   <= BIT_LO;
                            end else begin
                                Error <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                    RPT_LO: begin
                        if (rise) begin
                            if (in_window(width, BURST_MIN, BURST_MAX)) begin
                                if (Data != '0) begin
                                    Repeat <= 1'b1;
                                end
                            end else begin
                                Error <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Testbench for ir_nec_receiver: fixed frame vectors, randomized frames
// against a frame-level reference model, and hand-written sequences for
// repeat/release, malformed leader, stuck bus and mid-frame reset.
module tb_ir_nec_receiver;

    localparam int CLK_HZ        = 100_000;   // one tick per clock
    localparam int RELEASE_TICKS = 12000;

    logic        CLK;
    logic        RST_N;
    logic        Signal;
    logic [31:0] Data;
    logic        Valid;
    logic        Repeat;
    logic        Error;

    ir_nec_receiver #(
        .CLK_HZ       (CLK_HZ),
        .CHECK_INV    (1),
        .RELEASE_TICKS(RELEASE_TICKS)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Signal(Signal),
        .Data  (Data),
        .Valid (Valid),
        .Repeat(Repeat),
        .Error (Error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_rep    = 0;
    int n_err    = 0;
    int n_multi  = 0;
    int rep_cyc  = 0;

    // Frame-level reference state: last accepted word and when the key-held
    // interval was last refreshed.
    logic [31:0] model_data = '0;
    int          model_ref  = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST_N) begin
            if (Valid)  n_valid++;
            if (Error)  n_err++;
            if (Repeat) begin
                n_rep++;
                rep_cyc = cyc;
            end
            if ((int'(Valid) + int'(Repeat) + int'(Error)) > 1) n_multi++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_now();
        if ((cyc - model_ref) >= RELEASE_TICKS) return '0;
        return model_data;
    endfunction

    function automatic bit frame_ok(input logic [31:0] w);
        return w[31:24] == ~w[23:16];
    endfunction

    task automatic drive(input logic lvl, input int n);
        Signal = lvl;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Raise the line and report how many clocks until the given pulse shows.
    task automatic end_burst(input int which, output int lat);
        lat = -1;
        Signal = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK);
            #1;
            if (lat < 0 && ((which == 0 && Valid) || (which == 1 && Error) ||
                            (which == 2 && Repeat))) lat = k;
        end
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, $urandom_range(48, 62));
            drive(1'b1, w[i] ? $urandom_range(150, 190) : $urandom_range(48, 62));
        end
    endtask

    task automatic send_frame(input logic [31:0] w, output int lat_v, output int lat_e);
        int lat;
        drive(1'b0, $urandom_range(860, 940));
        drive(1'b1, $urandom_range(430, 470));
        send_bits(w, 32);
        drive(1'b0, $urandom_range(48, 62));
        lat = -1;
        lat_v = -1;
        lat_e = -1;
        Signal = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK);
            #1;
            if (lat_v < 0 && Valid) lat_v = k;
            if (lat_e < 0 && Error) lat_e = k;
        end
        drive(1'b1, 300);
    endtask

    task automatic send_repeat(output int lat);
        drive(1'b0, $urandom_range(870, 930));
        drive(1'b1, $urandom_range(200, 250));
        drive(1'b0, $urandom_range(48, 62));
        end_burst(2, lat);
        drive(1'b1, 200);
    endtask

    typedef struct {
        logic [31:0] word;
        logic        exp_valid;
        logic        exp_error;
        logic [31:0] exp_data;
    } vec_t;

    initial begin
        vec_t        vecs[2];
        int          lv, le, lat, v0, e0, r0, t0;
        logic [31:0] w, exp_d;
        logic [7:0]  cmd, inv;
        bit          ok;

        vecs[0] = '{32'h8F71E41B, 1'b0, 1'b1, 32'h0000_0000};
        vecs[1] = '{32'h8E71E41B, 1'b1, 1'b0, 32'h8E71E41B};

        Signal = 1'b1;
        RST_N  = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("reset_data",   Data,   32'h0);
        check("reset_valid",  {31'h0, Valid},  32'h0);
        check("reset_repeat", {31'h0, Repeat}, 32'h0);
        check("reset_error",  {31'h0, Error},  32'h0);
        RST_N = 1'b1;
        drive(1'b1, 20);

        // Repeat code while nothing is held: silent, no error.
        r0 = n_rep; e0 = n_err;
        send_repeat(lat);
        check("rpt_empty_count", n_rep - r0, 0);
        check("rpt_empty_err",   n_err - e0, 0);

        // Fixed vectors.
        foreach (vecs[i]) begin
            v0 = n_valid; e0 = n_err;
            send_frame(vecs[i].word, lv, le);
            if (vecs[i].exp_valid) begin
                model_data = vecs[i].word;
                model_ref  = cyc;
            end
            check($sformatf("vec%0d_valid", i), n_valid - v0, {31'h0, vecs[i].exp_valid});
            check($sformatf("vec%0d_error", i), n_err - e0, {31'h0, vecs[i].exp_error});
            check($sformatf("vec%0d_data", i), Data, vecs[i].exp_data);
            if (vecs[i].exp_valid) check($sformatf("vec%0d_latency", i), lv, 3);
        end

        // Randomized frames against the frame-level model.
        for (int i = 0; i < 2; i++) begin
            cmd = 8'($urandom);
            inv = (i == 1 || $urandom_range(0, 1) == 1) ? ~cmd : 8'($urandom);
            w   = {inv, cmd, 16'($urandom)};
            ok  = frame_ok(w);
            v0 = n_valid; e0 = n_err;
            send_frame(w, lv, le);
            if (ok) begin
                model_data = w;
                model_ref  = cyc;
            end
            check($sformatf("rnd%0d_valid", i), n_valid - v0, {31'h0, ok});
            check($sformatf("rnd%0d_error", i), n_err - e0, {31'h0, !ok});
            check($sformatf("rnd%0d_data", i), Data, model_now());
        end

        // Repeat while held, then release after the idle interval.
        exp_d = model_now();
        r0 = n_rep;
        send_repeat(lat);
        check("rpt_count", n_rep - r0, (exp_d != 0) ? 1 : 0);
        check("rpt_latency", lat, 3);
        check("rpt_data_held", Data, exp_d);
        model_ref = rep_cyc;
        t0 = rep_cyc;
        while (cyc < t0 + RELEASE_TICKS - 100) @(posedge CLK);
        #1;
        check("release_before", Data, exp_d);
        while (cyc < t0 + RELEASE_TICKS + 100) @(posedge CLK);
        #1;
        check("release_after", Data, 32'h0);
        model_data = '0;

        // Short 7 ms leader: error at its rising edge, then a normal frame.
        e0 = n_err; v0 = n_valid;
        drive(1'b0, 700);
        end_burst(1, lat);
        check("short_lead_err_lat", lat, 3);
        check("short_lead_valid", n_valid - v0, 0);
        drive(1'b1, 200);
        w = 32'h35CA_10EF;
        v0 = n_valid;
        send_frame(w, lv, le);
        model_data = w;
        model_ref  = cyc;
        check("after_err_valid", n_valid - v0, 1);
        check("after_err_data", Data, w);

        // Bus stuck low after the 16th bit: timeout error roughly 11 ms later.
        e0 = n_err; v0 = n_valid;
        drive(1'b0, 900);
        drive(1'b1, 450);
        send_bits(32'h1234_5678, 16);
        Signal = 1'b0;
        lat = -1;
        for (int k = 1; k <= 1300; k++) begin
            @(posedge CLK);
            #1;
            if (lat < 0 && Error) lat = k;
        end
        check("stuck_err_in_window", {31'h0, (lat >= 1090 && lat <= 1115)}, 32'h1);
        check("stuck_err_count", n_err - e0, 1);
        check("stuck_no_valid", n_valid - v0, 0);
        check("stuck_data_kept", Data, model_now());
        drive(1'b1, 200);

        // Reset in the middle of bit 20, then a complete frame.
        drive(1'b0, 900);
        drive(1'b1, 450);
        send_bits(32'hFFFF_FFFF, 20);
        drive(1'b0, 30);
        RST_N = 1'b0;
        Signal = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("midrst_data", Data, 32'h0);
        check("midrst_pulses", {29'h0, Valid, Repeat, Error}, 32'h0);
        model_data = '0;
        RST_N = 1'b1;
        drive(1'b1, 100);
        w = 32'hB748_00FF;
        v0 = n_valid; e0 = n_err;
        send_frame(w, lv, le);
        check("midrst_valid", n_valid - v0, 1);
        check("midrst_error", n_err - e0, 0);
        check("midrst_frame_data", Data, w);

        check("pulses_exclusive", n_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
